// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter, one byte per request, registered outputs
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_param
      $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
  endgenerate
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] data, data_n;
  logic busy, bit_end;
  always_comb begin
    busy = state inside {START, DATA, STOP};
    bit_end = busy && cnt == LAST;
    state_n = state;
    idx_n = idx;
    data_n = data;
    cnt_n = busy && !bit_end ? cnt + 1'b1 : '0;
    unique case (state)
      IDLE: begin
        state_n = i_Tx_DV ? START : IDLE;
        data_n = i_Tx_DV ? i_Tx_Byte : data;
      end
      START: begin
        state_n = bit_end ? DATA : START;
        idx_n = '0;
      end
      DATA: begin
        state_n = bit_end && idx == 3'd7 ? STOP : DATA;
        idx_n = bit_end ? idx + 1'b1 : idx;
      end
      STOP:    state_n = bit_end ? CLEANUP : STOP;
      CLEANUP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs follow the current state one cycle later, so every output is a flop
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      data <= data_n;
      o_Tx_Serial <= state == START ? 1'b0 : state == DATA ? data[idx] : 1'b1;
      o_Tx_Active <= busy;
      o_Tx_Done <= state == CLEANUP;
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of the 8N1 transmitter with CLKS_PER_BIT=4
module tb_uart_tx_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic active, serial, done;
  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(4)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Tx_DV(dv),
    .i_Tx_Byte(tx_byte),
    .o_Tx_Active(active),
    .o_Tx_Serial(serial),
    .o_Tx_Done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the request is accepted on the next posedge (cycle 0).
  // Samples cycles 0..41: bit centres are cycles 3+4k, active 1..40, done at 41.
  task automatic frame(input string tag, input logic [7:0] b, input int busy_at, input bit scramble);
    logic [9:0] bits;
    int act_err, dn, dn_at, fall;
    bits = '0;
    act_err = 0;
    dn = 0;
    dn_at = -1;
    fall = -1;
    dv = 1'b1;
    tx_byte = b;
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      if (c >= 3 && (c - 3) % 4 == 0) bits[(c-3)/4] = serial;
      if (active !== (c >= 1 && c <= 40)) act_err++;
      if (done === 1'b1) begin
        dn++;
        dn_at = c;
      end
      if (fall < 0 && serial === 1'b0) fall = c;
      dv = (c + 1 == busy_at);
      if (dv) tx_byte = 8'hFF;
      else if (scramble) tx_byte = 8'($urandom);
    end
    dv = 1'b0;
    check({tag, "_bits"}, 32'(bits), 32'({1'b1, b, 1'b0}));
    check({tag, "_fall"}, 32'(fall), 32'd1);
    check({tag, "_active_err"}, 32'(act_err), 32'd0);
    check({tag, "_done_cnt"}, 32'(dn), 32'd1);
    check({tag, "_done_at"}, 32'(dn_at), 32'd41);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int lows, acts, dns;
    lows = 0;
    acts = 0;
    dns = 0;
    dv = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (serial !== 1'b1) lows++;
      if (active !== 1'b0) acts++;
      if (done !== 1'b0) dns++;
    end
    check({tag, "_serial_low"}, 32'(lows), 32'd0);
    check({tag, "_active"}, 32'(acts), 32'd0);
    check({tag, "_done"}, 32'(dns), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_serial", 32'(serial), 32'd1);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    idle_watch("idle", 8);

    frame("b55", 8'h55, 0, 1'b0);
    idle_watch("gap", 4);

    // back-to-back: second request lands on the cycle right after done
    frame("bA3", 8'hA3, 0, 1'b0);
    frame("b0F", 8'h0F, 0, 1'b0);
    idle_watch("gap2", 4);

    frame("drop", 8'h00, 14, 1'b0);
    idle_watch("after_drop", 50);

    // abort 0x00 during data bit 3 (cycles 17..20), where the line is low
    dv = 1'b1;
    tx_byte = 8'h00;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      dv = 1'b0;
    end
    check("abort_pre_serial", 32'(serial), 32'd0);
    check("abort_pre_active", 32'(active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_serial", 32'(serial), 32'd1);
    check("abort_active", 32'(active), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    idle_watch("abort", 50);
    frame("after_abort", 8'h3C, 0, 1'b0);

    rst = 1'b1;
    dv = 1'b1;
    tx_byte = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    dv = 1'b0;
    idle_watch("rst_dv", 20);

    frame("hold", 8'hC6, 0, 1'b1);
    idle_watch("end", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
